// File: rtl/npu_job_launcher.sv
// Job sequencer: accepts a batch command, issues one start pulse per core run and waits for done between runs.
// Optional watchdog/ERR path is built only when NPU_LAUNCH_WATCHDOG_EN is defined.
module npu_job_launcher #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [CNT_W-1:0] i_cmd_runs,
  input  logic             i_abort,
  output logic             o_core_start,
  input  logic             i_core_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_runs_done,
  output logic             o_batch_done,
  output logic             o_timeout,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_cfg_check
    $error("npu_job_launcher: CNT_W, GAP_CYCLES and TIMEOUT_CYCLES must all be >= 1");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] runs_lat;
  logic [CNT_W-1:0] runs_done;
  logic             batch_done;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             gap_exit;
  logic             last_run;
  logic             wd_expire;

  assign accept   = i_cmd_valid && (state == IDLE);
  assign last_run = (runs_done == runs_lat);
  // A done level still high at the end of the gap holds the FSM here.
  assign gap_exit = (state == GAP) && (gap_cnt == GAP_LAST) && !i_core_done;

`ifdef NPU_LAUNCH_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_expire = (state == WAIT) && !i_core_done && (wd_cnt == WD_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        timeout_q <= 1'b0;
      end
      if (state == LAUNCH) begin
        wd_cnt <= '0;
      end else if ((state == WAIT) && !i_core_done && !wd_expire) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      // Abort in the expiry cycle wins, so the flag is not raised.
      if (wd_expire && !i_abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && (i_cmd_runs != '0)) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (i_core_done) begin
          state_nxt = GAP;
        end else if (wd_expire) begin
          state_nxt = ERR;
        end
      end
      GAP: begin
        if (gap_exit) begin
          state_nxt = last_run ? IDLE : LAUNCH;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
    if (i_abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      runs_lat   <= '0;
      runs_done  <= '0;
      batch_done <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            runs_lat   <= i_cmd_runs;
            runs_done  <= '0;
            batch_done <= (i_cmd_runs == '0);
          end
        end
        WAIT: begin
          if (i_core_done && !i_abort) begin
            runs_done <= runs_done + CNT_W'(1);
            gap_cnt   <= '0;
          end
        end
        GAP: begin
          if (gap_exit && last_run && !i_abort) begin
            batch_done <= 1'b1;
          end else if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready  = (state == IDLE);
  assign o_core_start = (state == LAUNCH);
  assign o_busy       = (state != IDLE);
  assign o_runs_done  = runs_done;
  assign o_batch_done = batch_done;
  assign o_state      = state;

endmodule

// File: doc/npu_job_launcher.md
# npu_job_launcher

Host-side job sequencer for the convolution core. Accepts a batch command over a valid/ready handshake. Issues one single-cycle start pulse per run to the core, then waits for the core's done level before launching the next run. Reports progress, batch completion and watchdog timeouts. Sits between the host/control register block and the core's start/done port pair; it is the initiator for the core's start/done protocol.

## Interface
Parameters:
- CNT_W, 8: width of run count and progress counter
- TIMEOUT_CYCLES, 4096: WAIT cycles before timeout (watchdog builds only)
- GAP_CYCLES, 2: minimum idle cycles between a done and the next start (≥1)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_cmd_valid  in  1  batch command valid
- o_cmd_ready  out  1  launcher can accept a command (high only in IDLE)
- i_cmd_runs  in  CNT_W  number of core runs in the batch
- i_abort  in  1  abort current batch, return to IDLE
- o_core_start  out  1  start pulse to core, exactly one cycle per run
- i_core_done  in  1  core done level
- o_busy  out  1  high in any state other than IDLE
- o_runs_done  out  CNT_W  runs completed in current/last batch
- o_batch_done  out  1  one-cycle pulse when a batch finishes normally
- o_timeout  out  1  sticky watchdog flag
- o_state  out  3  FSM encoding, for debug

## Operation
- States: IDLE=0, LAUNCH=1, WAIT=2, GAP=3, ERR=4. o_state shows the current state register.
- Reset values: state IDLE; o_core_start 0; o_busy 0; o_runs_done 0; o_batch_done 0; o_timeout 0; run latch 0; counters 0. o_cmd_ready is 1 (combinational from IDLE).
- IDLE: on i_cmd_valid & o_cmd_ready, latch i_cmd_runs, clear o_runs_done and o_timeout.
  - runs==0: stay IDLE; pulse o_batch_done next cycle.
  - runs>0: go to LAUNCH.
- LAUNCH: o_core_start=1 (decoded from state, one cycle); clear watchdog; next state WAIT.
- WAIT: if i_core_done=1, increment o_runs_done and go to GAP. Otherwise increment watchdog.
- GAP: count GAP_CYCLES cycles. Exit only once the count is reached and i_core_done=0; a stuck-high done holds GAP. Any done assertion in GAP is ignored (no double count).
  - If o_runs_done equals the latched runs: go to IDLE, with o_batch_done high in the first IDLE cycle.
  - Otherwise go to LAUNCH.
- ERR: entered only via watchdog. o_busy stays 1; no start issued. Leaves only on i_abort.
- i_abort in any non-IDLE state: next state IDLE, no o_batch_done, o_runs_done frozen. Abort beats done and timeout in the same cycle. Abort in IDLE has no effect.
- o_runs_done saturates nowhere: it is bounded by the latched runs (≤ 2^CNT_W−1).
- i_core_done outside WAIT/GAP is ignored.
- Mid-operation reset: the same synchronous reset values apply on the next edge, and o_core_start drops immediately with the state.

## Timing
- Command accepted at edge N → LAUNCH in cycle N+1 (o_core_start high) → WAIT from N+2.
- Done sampled high in WAIT at edge M → GAP from M+1. Next start no earlier than M+1+GAP_CYCLES.
- Per-run minimum period: 1 (LAUNCH) + 1 (WAIT) + GAP_CYCLES cycles.
- o_batch_done: one cycle, coincident with o_cmd_ready returning high. A new command may be accepted in that same cycle.
- Watchdog: with done never asserted, ERR is entered after exactly TIMEOUT_CYCLES WAIT cycles. o_timeout goes high the same cycle the state becomes ERR.

## Configuration
- NPU_LAUNCH_WATCHDOG_EN defined: the watchdog counter, the ERR state and o_timeout operate as above.
- NPU_LAUNCH_WATCHDOG_EN undefined: no watchdog logic. WAIT waits indefinitely, ERR is unreachable, and o_timeout is tied to 0.

## Test plan
- Reset with i_rst_n=0 for 2 cycles mid-WAIT → all outputs at reset values, o_cmd_ready=1, o_state=0.
- Command runs=3; core model asserts done 5 cycles after each start, holds it 2 cycles → exactly 3 start pulses, o_runs_done 1,2,3, one o_batch_done, no extra count from the held done.
- Command runs=0 → no o_core_start; o_batch_done pulse the cycle after accept; o_busy stays 0.
- Watchdog build, TIMEOUT_CYCLES=16, done never asserted → ERR 16 cycles after WAIT entry, o_timeout=1; i_abort → IDLE next cycle, o_timeout stays 1 until next accept.
- runs=4; i_abort asserted in the same cycle as done in run 2 → IDLE, o_runs_done=1, no o_batch_done.
- Back-to-back: second command valid during the o_batch_done cycle → accepted, start issued next cycle, o_runs_done cleared to 0.
